// File: rtl/cnn_l1_pkg.sv
// Shared constants for the first CNN layer: geometry, fixed 3x3 kernels, biases and requantisation.
// Channels 0-3 carry simple kernels (box, centre tap, negative box, large box); the rest are edge/blur filters.
package cnn_l1_pkg;

   localparam int IMG_W = 28;
   localparam int OUT_W = IMG_W / 2;
   localparam int N_CH  = 16;
   localparam int SHIFT = 7;
   localparam int ACC_W = 22;

   typedef enum logic [1:0] {PRELOAD, RUN, DONE} state_t;

   localparam logic signed [7:0] WEIGHTS [N_CH][3][3] = '{
      '{'{ 8'sd1,  8'sd1,  8'sd1}, '{ 8'sd1,   8'sd1,  8'sd1}, '{ 8'sd1,  8'sd1,  8'sd1}},
      '{'{ 8'sd0,  8'sd0,  8'sd0}, '{ 8'sd0,   8'sd127, 8'sd0}, '{ 8'sd0,  8'sd0,  8'sd0}},
      '{'{-8'sd1, -8'sd1, -8'sd1}, '{-8'sd1,  -8'sd1, -8'sd1}, '{-8'sd1, -8'sd1, -8'sd1}},
      '{'{ 8'sd127, 8'sd127, 8'sd127}, '{ 8'sd127, 8'sd127, 8'sd127}, '{ 8'sd127, 8'sd127, 8'sd127}},
      '{'{-8'sd1,  8'sd0,  8'sd1}, '{-8'sd2,   8'sd0,  8'sd2}, '{-8'sd1,  8'sd0,  8'sd1}},
      '{'{-8'sd1, -8'sd2, -8'sd1}, '{ 8'sd0,   8'sd0,  8'sd0}, '{ 8'sd1,  8'sd2,  8'sd1}},
      '{'{ 8'sd0,  8'sd1,  8'sd0}, '{ 8'sd1,  -8'sd4,  8'sd1}, '{ 8'sd0,  8'sd1,  8'sd0}},
      '{'{ 8'sd2,  8'sd2,  8'sd2}, '{ 8'sd2,   8'sd2,  8'sd2}, '{ 8'sd2,  8'sd2,  8'sd2}},
      '{'{ 8'sd1,  8'sd2,  8'sd1}, '{ 8'sd2,   8'sd4,  8'sd2}, '{ 8'sd1,  8'sd2,  8'sd1}},
      '{'{-8'sd1, -8'sd1, -8'sd1}, '{-8'sd1,   8'sd8, -8'sd1}, '{-8'sd1, -8'sd1, -8'sd1}},
      '{'{ 8'sd1,  8'sd0, -8'sd1}, '{ 8'sd1,   8'sd0, -8'sd1}, '{ 8'sd1,  8'sd0, -8'sd1}},
      '{'{ 8'sd3,  8'sd0, -8'sd3}, '{ 8'sd0,   8'sd5,  8'sd0}, '{-8'sd3,  8'sd0,  8'sd3}},
      '{'{ 8'sd0, -8'sd1,  8'sd0}, '{-8'sd1,   8'sd5, -8'sd1}, '{ 8'sd0, -8'sd1,  8'sd0}},
      '{'{ 8'sd1,  8'sd1,  8'sd0}, '{ 8'sd1,   8'sd0, -8'sd1}, '{ 8'sd0, -8'sd1, -8'sd1}},
      '{'{-8'sd2, -8'sd1,  8'sd0}, '{-8'sd1,   8'sd1,  8'sd1}, '{ 8'sd0,  8'sd1,  8'sd2}},
      '{'{ 8'sd4,  8'sd4,  8'sd4}, '{-8'sd8,  -8'sd8, -8'sd8}, '{ 8'sd4,  8'sd4,  8'sd4}}
   };

   // Biases are never positive, so an all-zero image maps to an all-zero feature map.
   localparam logic signed [15:0] BIAS [N_CH] = '{
      16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd16, -16'sd16, 16'sd0, -16'sd32,
      -16'sd64, 16'sd0, 16'sd0, -16'sd8, 16'sd0, 16'sd0, 16'sd0, -16'sd100
   };

   function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> SHIFT;
      if (acc[ACC_W-1]) return 8'd0;
      if (|sh[ACC_W-1:8]) return 8'hFF;
      return sh[7:0];
   endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// 4-row ring of image rows; combinational 3x3 window around (ctr_row, ctr_col), zero outside the image.
// Write pointer advances a slot every IMG_W accepted pixels; the caller decides which beats may be written.
module cnn_line_buffer
   import cnn_l1_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            wr_en,
   input  logic [7:0]      wr_data,
   input  logic [4:0]      ctr_row,
   input  logic [4:0]      ctr_col,
   output logic            row_done,
   output logic [8:0][7:0] win
);

   logic [7:0] mem [4][IMG_W];
   logic [1:0] wr_slot;
   logic [4:0] wr_col;
   logic [5:0] rr;
   logic [5:0] cc;

   assign row_done = wr_en && (wr_col == 5'(IMG_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_slot <= '0;
         wr_col  <= '0;
      end else if (clr) begin
         wr_slot <= '0;
         wr_col  <= '0;
      end else if (wr_en) begin
         if (row_done) begin
            wr_col  <= '0;
            wr_slot <= wr_slot + 2'd1;
         end else begin
            wr_col <= wr_col + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_slot][wr_col] <= wr_data;
   end

   // Row i always lives in slot i mod 4; a row/col of -1 wraps to 63 and falls into the padding test.
   always_comb begin
      win = '0;
      rr  = '0;
      cc  = '0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            rr = {1'b0, ctr_row} + 6'(dr) - 6'd1;
            cc = {1'b0, ctr_col} + 6'(dc) - 6'd1;
            if (rr < 6'(IMG_W) && cc < 6'(IMG_W)) win[dr*3+dc] = mem[rr[1:0]][cc[4:0]];
         end
      end
   end

endmodule

// File: rtl/cnn_l1_conv.sv
// 3x3/stride-2 conv, 16 channels, ReLU + requantise; 2 cycles from window fetch to output beat.
// Rows are requested one at a time via o_intr; beats arriving with no free line-buffer slot are dropped.
module cnn_l1_conv
   import cnn_l1_pkg::*;
(
   input  logic                axi_clk,
   input  logic                axi_rst_n,
   input  logic                i_data_valid,
   input  logic [7:0]          i_data,
   output logic [N_CH-1:0]     o_data_valid,
   output logic [8*N_CH-1:0]   o_convoledData,
   output logic                o_intr
);

   state_t state, state_nxt;

   logic [4:0]            rows_rcvd;
   logic [3:0]            out_row;
   logic [3:0]            out_col;
   logic                  req_out;
   logic                  accept, fetch, last_fetch, intr_cond, clr, row_done;
   logic [5:0]            free_lim;
   logic [5:0]            need;
   logic [8:0][7:0]       win;
   logic [8:0][7:0]       win_q;
   logic                  win_vld;
   logic [N_CH-1:0][7:0]  y;
   logic signed [ACC_W-1:0] acc, px, wt;

   // Output row r reads input rows 2r-1..2r+1: rows below 2r-1 may be overwritten.
   assign free_lim   = {1'b0, out_row, 1'b0} + 6'd3;
   assign need       = {1'b0, out_row, 1'b0} + 6'd2;
   assign last_fetch = fetch && (out_row == 4'(OUT_W - 1)) && (out_col == 4'(OUT_W - 1));

   cnn_line_buffer u_lb (
      .clk      (axi_clk),
      .rst_n    (axi_rst_n),
      .clr      (clr),
      .wr_en    (accept),
      .wr_data  (i_data),
      .ctr_row  ({out_row, 1'b0}),
      .ctr_col  ({out_col, 1'b0}),
      .row_done (row_done),
      .win      (win)
   );

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) state <= PRELOAD;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         PRELOAD: if (rows_rcvd == 5'd4) state_nxt = RUN;
         RUN:     if (last_fetch) state_nxt = DONE;
         DONE:    if (!win_vld && !o_data_valid[0]) state_nxt = PRELOAD;
         default: state_nxt = PRELOAD;
      endcase
   end

   always_comb begin
      accept    = 1'b0;
      fetch     = 1'b0;
      intr_cond = 1'b0;
      clr       = 1'b0;
      case (state)
         PRELOAD: accept = i_data_valid && (rows_rcvd < 5'd4);
         RUN: begin
            accept    = i_data_valid && ({1'b0, rows_rcvd} < free_lim) && (rows_rcvd < 5'(IMG_W));
            fetch     = ({1'b0, rows_rcvd} >= need);
            intr_cond = !req_out && ({1'b0, rows_rcvd} < free_lim) && (rows_rcvd < 5'(IMG_W));
         end
         DONE:    clr = 1'b1;
         default: clr = 1'b0;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         rows_rcvd <= '0;
         out_row   <= '0;
         out_col   <= '0;
         req_out   <= 1'b0;
         o_intr    <= 1'b0;
      end else if (clr) begin
         rows_rcvd <= '0;
         out_row   <= '0;
         out_col   <= '0;
         req_out   <= 1'b0;
         o_intr    <= 1'b0;
      end else begin
         o_intr <= intr_cond;
         if (accept && row_done) rows_rcvd <= rows_rcvd + 5'd1;
         if (intr_cond)                req_out <= 1'b1;
         else if (accept && row_done)  req_out <= 1'b0;
         if (fetch) begin
            if (out_col == 4'(OUT_W - 1)) begin
               out_col <= '0;
               out_row <= out_row + 4'd1;
            end else begin
               out_col <= out_col + 4'd1;
            end
         end
      end
   end

   // 16 parallel 9-tap MACs on the registered window, then ReLU/shift/saturate.
   always_comb begin
      y   = '0;
      acc = '0;
      px  = '0;
      wt  = '0;
      for (int k = 0; k < N_CH; k++) begin
         acc = ACC_W'(BIAS[k]);
         for (int t = 0; t < 9; t++) begin
            px  = ACC_W'(win_q[t]);
            wt  = ACC_W'(WEIGHTS[k][t/3][t%3]);
            acc = acc + px * wt;
         end
         y[k] = relu_sat(acc);
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         win_q          <= '0;
         win_vld        <= 1'b0;
         o_data_valid   <= '0;
         o_convoledData <= '0;
      end else begin
         win_vld      <= fetch;
         o_data_valid <= {N_CH{win_vld}};
         if (fetch)   win_q          <= win;
         if (win_vld) o_convoledData <= y;
      end
   end

endmodule

// File: tb/tb_cnn_l1_conv.sv
// Directed bench: whole images streamed through the layer, beats captured and compared to hand-derived values.
module tb_cnn_l1_conv;

   logic         axi_clk = 1'b0;
   logic         axi_rst_n;
   logic         i_data_valid;
   logic [7:0]   i_data;
   logic [15:0]  o_data_valid;
   logic [127:0] o_convoledData;
   logic         o_intr;

   int           n_assert = 0;
   int           n_fail   = 0;
   logic [7:0]   img [28][28];
   logic [127:0] beats [196];
   int           nbeats, nintr, early, dbl, sent;
   bit           tmo, preloaded;

   always #5 axi_clk = ~axi_clk;

   cnn_l1_conv dut (
      .axi_clk        (axi_clk),
      .axi_rst_n      (axi_rst_n),
      .i_data_valid   (i_data_valid),
      .i_data         (i_data),
      .o_data_valid   (o_data_valid),
      .o_convoledData (o_convoledData),
      .o_intr         (o_intr)
   );

   task automatic set_image(input int kind);
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++)
            img[r][c] = (kind == 1) ? 8'd255 : 8'd0;
      if (kind == 2) img[2][2] = 8'd128;
   endtask

   task automatic drive_row(input int r, input bit gaps);
      for (int c = 0; c < 28; c++) begin
         if (gaps && (c % 9 == 4)) begin
            @(negedge axi_clk);
            i_data_valid = 1'b0;
         end
         @(negedge axi_clk);
         i_data_valid = 1'b1;
         i_data       = img[r][c];
      end
   endtask

   task automatic run_image(input int delay, input bit gaps);
      nbeats = 0; nintr = 0; early = 0; dbl = 0; sent = 0;
      tmo = 1'b0; preloaded = 1'b0;
      fork
         begin
            for (int r = 0; r < 4; r++) drive_row(r, 1'b0);
            @(negedge axi_clk);
            i_data_valid = 1'b0;
            preloaded = 1'b1;
            for (int r = 4; r < 28; r++) begin
               int w;
               w = 0;
               while (nintr < r - 3 && w < 3000) begin
                  @(negedge axi_clk);
                  w++;
               end
               if (nintr < r - 3) begin
                  tmo = 1'b1;
                  break;
               end
               repeat (delay) @(negedge axi_clk);
               drive_row(r, gaps);
               @(negedge axi_clk);
               i_data_valid = 1'b0;
               sent++;
            end
         end
         begin
            int cyc, tail;
            cyc = 0; tail = 0;
            while (cyc < 20000 && tail < 60) begin
               @(negedge axi_clk);
               cyc++;
               if (o_intr) begin
                  if (!preloaded) early++;
                  if (nintr != sent) dbl++;
                  nintr++;
               end
               if (o_data_valid != 16'h0) begin
                  if (nbeats < 196) beats[nbeats] = o_convoledData;
                  nbeats++;
               end
               if (nbeats >= 196) tail++;
            end
            if (cyc >= 20000) tmo = 1'b1;
         end
      join
   endtask

   task automatic test_reset;
      axi_rst_n = 1'b0; i_data_valid = 1'b0; i_data = 8'd0;
      repeat (3) @(negedge axi_clk);
      n_assert++; if (o_data_valid !== 16'h0) begin n_fail++; $display("FAIL reset_valid got %h want 0000", o_data_valid); end
      n_assert++; if (o_convoledData !== 128'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", o_convoledData); end
      n_assert++; if (o_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr got %b want 0", o_intr); end
      axi_rst_n = 1'b1;
      repeat (2) @(negedge axi_clk);
   endtask

   task automatic test_zero_image;
      set_image(0);
      run_image(0, 1'b0);
      n_assert++; if (tmo) begin n_fail++; $display("FAIL zero_timeout got 1 want 0"); end
      n_assert++; if (nbeats != 196) begin n_fail++; $display("FAIL zero_beats got %0d want 196", nbeats); end
      n_assert++; if (nintr != 24) begin n_fail++; $display("FAIL zero_intr got %0d want 24", nintr); end
      n_assert++; if (early != 0) begin n_fail++; $display("FAIL zero_early_intr got %0d want 0", early); end
      for (int b = 0; b < 196 && b < nbeats; b++) begin
         n_assert++;
         if (beats[b] !== 128'h0) begin n_fail++; $display("FAIL zero_beat %0d got %h want 0", b, beats[b]); end
      end
   endtask

   task automatic test_flat_image;
      logic [31:0] exp;
      set_image(1);
      run_image(0, 1'b0);
      n_assert++; if (tmo) begin n_fail++; $display("FAIL flat_timeout got 1 want 0"); end
      n_assert++; if (nbeats != 196) begin n_fail++; $display("FAIL flat_beats got %0d want 196", nbeats); end
      for (int b = 0; b < 196 && b < nbeats; b++) begin
         exp = {8'd255, 8'd0, 8'd253, (b == 0) ? 8'd7 : ((b < 14 || b % 14 == 0) ? 8'd11 : 8'd17)};
         n_assert++;
         if (beats[b][31:0] !== exp) begin n_fail++; $display("FAIL flat_beat %0d got %h want %h", b, beats[b][31:0], exp); end
      end
   endtask

   task automatic test_single_pixel;
      logic [31:0] exp;
      set_image(2);
      run_image(0, 1'b0);
      n_assert++; if (nbeats != 196) begin n_fail++; $display("FAIL pix_beats got %0d want 196", nbeats); end
      for (int b = 0; b < 196 && b < nbeats; b++) begin
         exp = (b == 15) ? {8'd127, 8'd0, 8'd127, 8'd1} : 32'h0;
         n_assert++;
         if (beats[b][31:0] !== exp) begin n_fail++; $display("FAIL pix_beat %0d got %h want %h", b, beats[b][31:0], exp); end
      end
   endtask

   task automatic test_paced;
      logic [31:0] exp;
      set_image(1);
      run_image(100, 1'b1);
      n_assert++; if (tmo) begin n_fail++; $display("FAIL paced_timeout got 1 want 0"); end
      n_assert++; if (nbeats != 196) begin n_fail++; $display("FAIL paced_beats got %0d want 196", nbeats); end
      n_assert++; if (nintr != 24) begin n_fail++; $display("FAIL paced_intr got %0d want 24", nintr); end
      n_assert++; if (dbl != 0) begin n_fail++; $display("FAIL paced_double_request got %0d want 0", dbl); end
      for (int b = 0; b < 196 && b < nbeats; b++) begin
         exp = {8'd255, 8'd0, 8'd253, (b == 0) ? 8'd7 : ((b < 14 || b % 14 == 0) ? 8'd11 : 8'd17)};
         n_assert++;
         if (beats[b][31:0] !== exp) begin n_fail++; $display("FAIL paced_beat %0d got %h want %h", b, beats[b][31:0], exp); end
      end
   endtask

   task automatic test_midreset;
      bit seen;
      logic [31:0] exp;
      set_image(1);
      for (int r = 0; r < 4; r++) drive_row(r, 1'b0);
      @(negedge axi_clk);
      i_data_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge axi_clk);
         if (o_data_valid == 16'hFFFF) seen = 1'b1;
      end
      n_assert++; if (!seen) begin n_fail++; $display("FAIL midrst_first_beat got none want beat within 200 cycles"); end
      n_assert++;
      if (o_convoledData[31:0] !== 32'hFF00FD07) begin
         n_fail++; $display("FAIL midrst_corner got %h want ff00fd07", o_convoledData[31:0]);
      end
      @(posedge axi_clk);
      #2 axi_rst_n = 1'b0;
      #1;
      n_assert++; if (o_data_valid !== 16'h0) begin n_fail++; $display("FAIL midrst_valid got %h want 0000", o_data_valid); end
      n_assert++; if (o_convoledData !== 128'h0) begin n_fail++; $display("FAIL midrst_data got %h want 0", o_convoledData); end
      n_assert++; if (o_intr !== 1'b0) begin n_fail++; $display("FAIL midrst_intr got %b want 0", o_intr); end
      repeat (3) @(negedge axi_clk);
      axi_rst_n = 1'b1;
      @(negedge axi_clk);
      set_image(2);
      run_image(0, 1'b0);
      n_assert++; if (nbeats != 196) begin n_fail++; $display("FAIL midrst_beats got %0d want 196", nbeats); end
      n_assert++; if (nintr != 24) begin n_fail++; $display("FAIL midrst_intr_count got %0d want 24", nintr); end
      for (int b = 0; b < 196 && b < nbeats; b++) begin
         exp = (b == 15) ? {8'd127, 8'd0, 8'd127, 8'd1} : 32'h0;
         n_assert++;
         if (beats[b][31:0] !== exp) begin n_fail++; $display("FAIL midrst_beat %0d got %h want %h", b, beats[b][31:0], exp); end
      end
   endtask

   initial begin
      test_reset;
      test_zero_image;
      test_flat_image;
      test_single_pixel;
      test_paced;
      test_midreset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
